// File: rtl/mojo_avr_pkg.sv
// Shared constants, frame layout and channel sequencing helper for the Mojo AVR ADC link.
package mojo_avr_pkg;

    localparam logic [3:0] CHAN_NONE     = 4'hF;
    localparam int         FRAME_BITS    = 16;
    localparam int         MAX_CHANNELS  = 15;
    // Offsets inside the 16-bit shift register once a frame is complete (byte0 in [15:8]).
    localparam int         SAMPLE_LO_LSB = 8;
    localparam int         CHAN_LSB      = 4;
    localparam int         SAMPLE_HI_LSB = 0;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    // Lowest enabled index above cur, else lowest enabled overall; CHAN_NONE for an empty mask.
    function automatic logic [3:0] next_chan(input logic [MAX_CHANNELS-1:0] mask,
                                             input logic [3:0]              cur);
        logic [3:0] first_idx;
        logic [3:0] after_idx;
        logic       have_first;
        logic       have_after;
        first_idx  = CHAN_NONE;
        after_idx  = CHAN_NONE;
        have_first = 1'b0;
        have_after = 1'b0;
        for (int i = 0; i < MAX_CHANNELS; i++) begin
            if (mask[i] && !have_first) begin
                first_idx  = 4'(i);
                have_first = 1'b1;
            end
            if (mask[i] && !have_after && (4'(i) > cur)) begin
                after_idx  = 4'(i);
                have_after = 1'b1;
            end
        end
        return have_after ? after_idx : first_idx;
    endfunction

endpackage

// File: rtl/mojo_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin with rising/falling edge strobes.
module mojo_sync_edge
    import mojo_avr_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   q_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= '0;
            q_d    <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], d};
            q_d    <= sync_r[SYNC_STAGES-1];
        end
    end

    assign q    = sync_r[SYNC_STAGES-1];
    assign rise = q & ~q_d;
    assign fall = ~q & q_d;

endmodule

// File: rtl/mojo_avr_adc_stream.sv
// SPI slave endpoint for AVR-pushed ADC frames: channel sequencing, frame decode, valid/ready output.
module mojo_avr_adc_stream
    import mojo_avr_pkg::*;
#(
    parameter  int NUM_CHANNELS = 10,
    parameter  int SAMPLE_W     = 10,
    parameter  int SYNC_STAGES  = 2,
    parameter  int CNT_W        = 8,
    localparam int CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [NUM_CHANNELS-1:0] chan_mask,
    input  logic                    spi_sck,
    input  logic                    spi_ss,
    input  logic                    spi_mosi,
    output logic                    spi_miso,
    output logic                    spi_miso_oe,
    output logic [3:0]              spi_channel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CH_W-1:0]         out_chan,
    output logic [SAMPLE_W-1:0]     out_sample,
    output logic [CNT_W-1:0]        overflow_cnt,
    output logic                    frame_err
);

    logic sck_q, sck_rise, sck_fall;
    logic ss_q, ss_rise, ss_fall;
    logic mosi_q, mosi_rise, mosi_fall;
    logic unused_edges;

    mojo_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
        .clk(clk), .rst_n(rst_n), .d(spi_sck), .q(sck_q), .rise(sck_rise), .fall(sck_fall));
    mojo_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss (
        .clk(clk), .rst_n(rst_n), .d(spi_ss), .q(ss_q), .rise(ss_rise), .fall(ss_fall));
    mojo_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .d(spi_mosi), .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall));

    assign unused_edges = ^{sck_q, sck_fall, ss_rise, ss_fall, mosi_rise, mosi_fall};

    state_t                  state, state_n;
    logic [3:0]              bit_cnt;
    logic [FRAME_BITS-1:0]   shift_reg;
    logic                    armed;
    logic                    ss_low;
    logic                    cnt_clr, shift_en, abort;
    logic [3:0]              frame_chan;
    logic [11:0]             frame_sample;
    logic                    chan_ok, commit_ok, stall, load;
    logic [MAX_CHANNELS-1:0] mask_ext;

    // The ss synchroniser resets low, so a frame only starts after ss has been seen high once.
    assign ss_low       = ~ss_q;
    assign spi_miso     = 1'b0;
    assign spi_miso_oe  = armed & ss_low;
    assign frame_chan   = shift_reg[CHAN_LSB +: 4];
    assign frame_sample = {shift_reg[SAMPLE_HI_LSB +: 4], shift_reg[SAMPLE_LO_LSB +: 8]};
    assign chan_ok      = int'(frame_chan) < NUM_CHANNELS;
    assign stall        = out_valid & ~out_ready;
    assign commit_ok    = (state == COMMIT) & chan_ok;
    assign load         = commit_ok & ~stall;
    assign mask_ext     = MAX_CHANNELS'(chan_mask);

    always_comb begin
        state_n  = state;
        cnt_clr  = 1'b0;
        shift_en = 1'b0;
        abort    = 1'b0;
        case (state)
            IDLE: begin
                if (ss_low && armed) begin
                    state_n = SHIFT;
                    cnt_clr = 1'b1;
                end
            end
            SHIFT: begin
                if (!ss_low) begin
                    state_n = IDLE;
                    abort   = (bit_cnt != 4'd0);
                end else if (sck_rise) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 4'(FRAME_BITS - 1)) state_n = COMMIT;
                end
            end
            COMMIT: begin
                cnt_clr = 1'b1;
                state_n = ss_low ? SHIFT : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (shift_en) shift_reg <= {shift_reg[FRAME_BITS-2:0], mosi_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            armed        <= 1'b0;
            out_valid    <= 1'b0;
            out_chan     <= '0;
            out_sample   <= '0;
            overflow_cnt <= '0;
            frame_err    <= 1'b0;
            spi_channel  <= CHAN_NONE;
        end else begin
            state <= state_n;
            if (ss_q) armed <= 1'b1;

            if (cnt_clr)       bit_cnt <= '0;
            else if (shift_en) bit_cnt <= bit_cnt + 4'd1;

            if (((state == COMMIT) && !chan_ok) || abort) frame_err <= 1'b1;

            // A same-cycle load wins over the accept, keeping out_valid high with fresh data.
            if (load) begin
                out_valid  <= 1'b1;
                out_chan   <= CH_W'(frame_chan);
                out_sample <= SAMPLE_W'(frame_sample);
            end else if (out_ready) begin
                out_valid  <= 1'b0;
            end

            if (commit_ok && stall && (overflow_cnt != {CNT_W{1'b1}}))
                overflow_cnt <= overflow_cnt + CNT_W'(1);

            if (!enable || (chan_mask == '0))
                spi_channel <= CHAN_NONE;
            else if (commit_ok)
                spi_channel <= next_chan(mask_ext, frame_chan);
            else if ((state == IDLE) && (spi_channel == CHAN_NONE))
                spi_channel <= next_chan(mask_ext, CHAN_NONE);
        end
    end

endmodule
